// File: rtl/pcm_sample_fifo.sv
// PCM sample conditioning plus show-ahead FIFO in the decimator clock domain (mclk1).
// Define PCM_DC_BLOCK_EN to enable the DC tracker with saturation; otherwise samples are offset-binary converted.
module pcm_sample_fifo #(
   parameter int DEPTH    = 16,
   parameter int DC_SHIFT = 6
) (
   input  logic                     mclk1,
   input  logic                     reset,
   input  logic [7:0]               sample_in,
   input  logic                     sample_en,
   output logic [7:0]               m_data,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   input  logic                     clr_ovf
);

   localparam int             AW       = $clog2(DEPTH);
   localparam logic [AW:0]    FULL_LVL = (AW+1)'(DEPTH);

   generate
      if (DEPTH < 4 || (1 << AW) != DEPTH) begin : g_bad_depth
         $error("pcm_sample_fifo: DEPTH must be a power of two >= 4");
      end
      if (DC_SHIFT < 2 || DC_SHIFT > 12) begin : g_bad_shift
         $error("pcm_sample_fifo: DC_SHIFT must be in 2..12");
      end
   endgenerate

   logic [7:0] y;

`ifdef PCM_DC_BLOCK_EN
   localparam int               ACC_W   = 8 + DC_SHIFT;
   localparam logic [ACC_W-1:0] ACC_RST = ACC_W'(128) << DC_SHIFT;

   logic [ACC_W-1:0] dc_acc;
   logic [7:0]       dc;
   logic signed [8:0] diff;

   assign dc   = dc_acc[ACC_W-1:DC_SHIFT];
   assign diff = $signed({1'b0, sample_in}) - $signed({1'b0, dc});

   always_comb begin
      if (diff > 9'sd127)
         y = 8'h7F;
      else if (diff < -9'sd128)
         y = 8'h80;
      else
         y = diff[7:0];
   end

   // dc_acc stays within [0, 256<<DC_SHIFT) because dc tracks its own top bits.
   always_ff @(posedge mclk1 or negedge reset) begin
      if (!reset)
         dc_acc <= ACC_RST;
      else if (sample_en)
         dc_acc <= dc_acc + ACC_W'(sample_in) - ACC_W'(dc);
   end
`else
   assign y = {~sample_in[7], sample_in[6:0]};
`endif

   logic [7:0] y_reg;
   logic       y_vld;

   always_ff @(posedge mclk1 or negedge reset) begin
      if (!reset) begin
         y_reg <= '0;
         y_vld <= 1'b0;
      end else begin
         y_vld <= sample_en;
         if (sample_en)
            y_reg <= y;
      end
   end

   // Stream: a word transfers on each mclk1 edge where m_valid & m_ready;
   // m_valid depends only on occupancy, and m_data is the head word, stable until popped.
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          full, pop, wr;

   assign m_valid = (level != '0);
   assign m_data  = mem[rd_ptr];
   assign full    = (level == FULL_LVL);
   assign pop     = m_valid & m_ready;
   assign wr      = y_vld & (~full | pop);

   always_ff @(posedge mclk1 or negedge reset) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else begin
         if (wr) begin
            mem[wr_ptr] <= y_reg;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({wr, pop})
            2'b10:   level <= level + (AW+1)'(1);
            2'b01:   level <= level - (AW+1)'(1);
            default: level <= level;
         endcase
         // A drop in the same cycle as clr_ovf keeps the flag set.
         if (y_vld & full & ~pop)
            overflow <= 1'b1;
         else if (clr_ovf)
            overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pcm_sample_fifo.sv
// Directed bench for pcm_sample_fifo (DEPTH=16, DC_SHIFT=6); honours PCM_DC_BLOCK_EN like the design.
module tb_pcm_sample_fifo;

   logic       mclk1;
   logic       reset;
   logic [7:0] sample_in;
   logic       sample_en;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready;
   logic [4:0] level;
   logic       overflow;
   logic       clr_ovf;

   int tests = 0;
   int fails = 0;
   logic [7:0] exp_q[$];
   logic [7:0] got;
   logic [7:0] e;

   pcm_sample_fifo #(.DEPTH(16), .DC_SHIFT(6)) dut (
      .mclk1     (mclk1),
      .reset     (reset),
      .sample_in (sample_in),
      .sample_en (sample_en),
      .m_data    (m_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .level     (level),
      .overflow  (overflow),
      .clr_ovf   (clr_ovf)
   );

   initial mclk1 = 1'b0;
   always #5 mclk1 = ~mclk1;

`ifdef PCM_DC_BLOCK_EN
   int m_acc;
   function automatic logic [7:0] conv(input logic [7:0] x);
      int dc, d;
      dc = m_acc >> 6;
      d  = int'(x) - dc;
      m_acc = m_acc + int'(x) - dc;
      if (d > 127) return 8'h7F;
      if (d < -128) return 8'h80;
      return d[7:0];
   endfunction
`else
   function automatic logic [7:0] conv(input logic [7:0] x);
      return x ^ 8'h80;
   endfunction
`endif

   task automatic tick();
      @(posedge mclk1);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One strobe into an empty FIFO with m_ready=1: invisible after edge k, head after k+1, popped at k+2.
   task automatic strobe_and_see(input logic [7:0] x, output logic [7:0] data);
      sample_en = 1'b1;
      sample_in = x;
      tick();
      sample_en = 1'b0;
      check("lat_not_yet", {15'd0, m_valid}, 16'd0);
      tick();
      check("lat_valid", {15'd0, m_valid}, 16'd1);
      data = m_data;
      tick();
      check("lat_popped", {15'd0, m_valid}, 16'd0);
   endtask

   initial begin
      reset = 1'b0; sample_in = '0; sample_en = 1'b0; m_ready = 1'b0; clr_ovf = 1'b0;
`ifdef PCM_DC_BLOCK_EN
      m_acc = 128 << 6;
`endif
      // Reset state, then idle for 100 cycles.
      repeat (3) tick();
      check("rst_level", 16'(level), 16'd0);
      check("rst_valid", {15'd0, m_valid}, 16'd0);
      check("rst_ovf", {15'd0, overflow}, 16'd0);
      check("rst_data", {8'd0, m_data}, 16'd0);
      reset = 1'b1;
      for (int i = 0; i < 100; i++) begin
         tick();
         check("idle_level", 16'(level), 16'd0);
         check("idle_valid", {15'd0, m_valid}, 16'd0);
         check("idle_ovf", {15'd0, overflow}, 16'd0);
      end

      m_ready = 1'b1;
`ifndef PCM_DC_BLOCK_EN
      strobe_and_see(8'h80, got); check("conv_80", {8'd0, got}, 16'h0000);
      strobe_and_see(8'hFF, got); check("conv_ff", {8'd0, got}, 16'h007F);
      strobe_and_see(8'h00, got); check("conv_00", {8'd0, got}, 16'h0080);
`else
      for (int i = 0; i < 1000; i++) begin
         strobe_and_see(8'd200, got);
         e = conv(8'd200);
         check("dc_model", {8'd0, got}, {8'd0, e});
         if (i == 0) check("dc_first", {8'd0, got}, 16'h0048);
         if (i >= 900) check("dc_settle", {15'd0, ($signed(got) >= -8'sd1 && $signed(got) <= 8'sd1)}, 16'd1);
      end
      strobe_and_see(8'd0, got);
      e = conv(8'd0);
      check("dc_sat_neg", {8'd0, got}, 16'h0080);
`endif

      // Back-to-back strobes 1..20 with the consumer stalled.
      m_ready = 1'b0;
      for (int v = 1; v <= 20; v++) begin
         sample_en = 1'b1;
         sample_in = 8'(v);
         e = conv(8'(v));
         if (v <= 16) exp_q.push_back(e);
         tick();
      end
      sample_en = 1'b0;
      tick();
      check("fill_level", 16'(level), 16'd16);
      check("fill_ovf", {15'd0, overflow}, 16'd1);
      tick();
      check("fill_level_hold", 16'(level), 16'd16);
      m_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check("drain_valid", {15'd0, m_valid}, 16'd1);
         check("drain_data", {8'd0, m_data}, {8'd0, exp_q.pop_front()});
         tick();
      end
      for (int i = 0; i < 3; i++) begin
         check("empty_level", 16'(level), 16'd0);
         check("empty_valid", {15'd0, m_valid}, 16'd0);
         tick();
      end

      // Full FIFO behaviour: coincident write/pop, set-beats-clear, clear.
      m_ready = 1'b0;
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      check("clr_ovf", {15'd0, overflow}, 16'd0);
      for (int v = 0; v < 16; v++) begin
         sample_en = 1'b1;
         sample_in = 8'h30 + 8'(v);
         exp_q.push_back(conv(8'h30 + 8'(v)));
         tick();
      end
      sample_en = 1'b0;
      tick();
      check("full_level", 16'(level), 16'd16);
      check("full_no_ovf", {15'd0, overflow}, 16'd0);
      sample_en = 1'b1;
      sample_in = 8'h55;
      e = conv(8'h55);
      tick();
      sample_en = 1'b0;
      m_ready = 1'b1;
      check("coinc_head", {8'd0, m_data}, {8'd0, exp_q.pop_front()});
      exp_q.push_back(e);
      tick();
      m_ready = 1'b0;
      check("coinc_level", 16'(level), 16'd16);
      check("coinc_ovf", {15'd0, overflow}, 16'd0);
      sample_en = 1'b1;
      sample_in = 8'h66;
      e = conv(8'h66);
      tick();
      sample_en = 1'b0;
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      check("set_beats_clr", {15'd0, overflow}, 16'd1);
      check("drop_level", 16'(level), 16'd16);
      check("drop_head", {8'd0, m_data}, {8'd0, exp_q[0]});
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      check("clr_after_set", {15'd0, overflow}, 16'd0);
      m_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         check("part_drain", {8'd0, m_data}, {8'd0, exp_q.pop_front()});
         tick();
      end
      m_ready = 1'b0;
      check("part_level", 16'(level), 16'd7);

      // Reset with level=7 and a sample in flight.
      sample_en = 1'b1;
      sample_in = 8'h77;
      tick();
      sample_en = 1'b0;
      reset = 1'b0;
      #1;
      check("async_rst_level", 16'(level), 16'd0);
      tick();
      reset = 1'b1;
      tick();
      check("post_rst_level", 16'(level), 16'd0);
      check("post_rst_valid", {15'd0, m_valid}, 16'd0);
      check("post_rst_ovf", {15'd0, overflow}, 16'd0);
      exp_q.delete();
`ifdef PCM_DC_BLOCK_EN
      m_acc = 128 << 6;
`endif
      m_ready = 1'b1;
      strobe_and_see(8'd128, got);
      e = conv(8'd128);
      check("post_rst_mid", {8'd0, got}, 16'h0000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
